// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word addresses to the unified memory, captures
// returned words with their PC into a small prefetch FIFO, and handles redirects.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] pc,
    output logic        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [15:0]     mem_addr_q, mem_addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]     fifo_word_q [FIFO_DEPTH];
    logic [15:0]     fifo_pc_q   [FIFO_DEPTH];

    logic            push_s;
    logic            pop_s;
    logic            wr_en_s;
    logic [CW-1:0]   next_count_s;

    assign instr_valid = (count_q != {CW{1'b0}});
    assign instr       = fifo_word_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign mem_addr    = mem_addr_q;
    assign pc          = pc_q;
    assign busy        = (state_q != ST_IDLE);

    // Next-state logic: fetch sequencing, FIFO bookkeeping and redirect priority.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        push_s       = 1'b0;
        wr_en_s      = 1'b0;
        pop_s        = instr_valid && instr_ready;
        next_count_s = count_q;

        if (redirect) begin
            // Flush everything; any push or pop this cycle is dropped.
            pc_d     = redirect_pc;
            state_d  = ST_IDLE;
            count_d  = {CW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            push_s = (state_q == ST_WAIT) && mem_ready;
            next_count_s = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

            case (state_q)
                ST_IDLE: begin
                    if ((count_q < DEPTH_C) && !hold) begin
                        mem_addr_d = pc_q;
                        state_d    = ST_SETTLE;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        pc_d = pc_q + 16'd1;
                        if ((next_count_s < DEPTH_C) && !hold) begin
                            mem_addr_d = pc_q + 16'd1;
                            state_d    = ST_SETTLE;
                        end else begin
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            wr_en_s  = push_s;
            count_d  = next_count_s;
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_s};
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_s};
        end
    end

    // State, pointer and FIFO storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            count_q    <= {CW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_word_q[i] <= 16'h0000;
                fifo_pc_q[i]   <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (wr_en_s) begin
                fifo_word_q[wr_ptr_q] <= mem_data;
                fifo_pc_q[wr_ptr_q]   <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a memory model that drops ready for one
// cycle whenever its address changes.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] sb_q [$];

    logic [15:0] m_last  = 16'hFFFF;
    logic        m_ready = 1'b0;

    fetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        case (a)
            16'h0000: word = 16'h1111;
            16'h0001: word = 16'h2222;
            16'h0002: word = 16'h3333;
            16'h0003: word = 16'h4444;
            default:  word = a ^ 16'h5A5A;
        endcase
    endfunction

    // Memory model: a new address costs one not-ready cycle.
    always @(posedge clk) begin
        m_ready <= (mem_addr == m_last);
        m_last  <= mem_addr;
    end
    assign mem_data  = word(m_last);
    assign mem_ready = m_ready;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        instr_ready = 1'b0;
        sb_q.delete();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hold = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        instr_ready = 1'b0;
        #2;
        checks++;
        if ({instr_valid, busy, mem_addr, pc, instr, instr_pc} !== {1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state got v=%b b=%b a=%h pc=%h i=%h ipc=%h want all zero",
                     instr_valid, busy, mem_addr, pc, instr, instr_pc);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_issue got busy=%b want 1", busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit found = 1'b0;
        do_reset();
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (mem_addr == 16'h0001 && mem_ready == 1'b0 && busy) found = 1'b1;
        end
        checks++;
        if (!found || instr_valid !== 1'b1 || pc !== 16'h0001) begin
            errors++;
            $display("FAIL midwait_setup got found=%b v=%b pc=%h want 1 1 0001", found, instr_valid, pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_valid, busy, mem_addr, pc} !== {1'b0, 1'b0, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL midwait_reset got v=%b b=%b a=%h pc=%h want 0 0 0000 0000",
                     instr_valid, busy, mem_addr, pc);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int got = 0;
        int t_prev = 0;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) sb_q.push_back({16'(k), word(16'(k))});
        for (int i = 0; i < 40 && got < 4; i++) begin
            step();
            if (instr_valid) begin
                checks++;
                if ({instr_pc, instr} !== sb_q[0]) begin
                    errors++;
                    $display("FAIL stream_entry got %h want %h", {instr_pc, instr}, sb_q[0]);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - t_prev != 3) begin
                        errors++;
                        $display("FAIL stream_gap got %0d want 3", cyc - t_prev);
                    end
                end
                t_prev = cyc;
                void'(sb_q.pop_front());
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL stream_timeout got %0d entries want 4", got);
        end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) sb_q.push_back({16'(k), word(16'(k))});
        for (int i = 0; i < 15; i++) step();
        checks++;
        if ({instr_valid, instr_pc, pc, mem_addr, busy} !== {1'b1, 16'h0000, 16'h0002, 16'h0001, 1'b0}) begin
            errors++;
            $display("FAIL bp_full got v=%b ipc=%h pc=%h a=%h b=%b want 1 0000 0002 0001 0",
                     instr_valid, instr_pc, pc, mem_addr, busy);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || {instr_pc, instr} !== sb_q[0]) begin
                errors++;
                $display("FAIL bp_drain got v=%b %h want 1 %h", instr_valid, {instr_pc, instr}, sb_q[0]);
            end
            void'(sb_q.pop_front());
            step();
        end
        checks++;
        if ({instr_valid, mem_addr} !== {1'b0, 16'h0002}) begin
            errors++;
            $display("FAIL bp_reissue got v=%b a=%h want 0 0002", instr_valid, mem_addr);
        end
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (instr_valid) found = 1'b1;
        end
        checks++;
        if (!found || {instr_pc, instr} !== sb_q[0]) begin
            errors++;
            $display("FAIL bp_next got found=%b %h want %h", found, {instr_pc, instr}, sb_q[0]);
        end
        sb_q.delete();
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) sb_q.push_back({16'(k), word(16'(k))});
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (instr_valid) begin
                if (instr_pc == 16'h0004) begin
                    instr_ready = 1'b0;
                    found = 1'b1;
                end else begin
                    checks++;
                    if (sb_q.size() == 0 || {instr_pc, instr} !== sb_q[0]) begin
                        errors++;
                        $display("FAIL rd_prefix got %h", {instr_pc, instr});
                    end
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                end
            end
        end
        checks++;
        if (!found || mem_addr !== 16'h0005 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_setup got found=%b a=%h b=%b want 1 0005 1", found, mem_addr, busy);
        end
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        sb_q.delete();
        sb_q.push_back({16'h0040, word(16'h0040)});
        step();
        redirect = 1'b0;
        checks++;
        if ({instr_valid, pc, busy} !== {1'b0, 16'h0040, 1'b0}) begin
            errors++;
            $display("FAIL rd_flush got v=%b pc=%h b=%b want 0 0040 0", instr_valid, pc, busy);
        end
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (instr_valid) found = 1'b1;
        end
        checks++;
        if (!found || {instr_pc, instr} !== sb_q[0]) begin
            errors++;
            $display("FAIL rd_first got found=%b %h want %h", found, {instr_pc, instr}, sb_q[0]);
        end
        sb_q.delete();
    endtask

    task automatic test_simultaneous();
        bit seen_low = 1'b0;
        bit found = 1'b0;
        do_reset();
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (mem_addr == 16'h0001 && !mem_ready) seen_low = 1'b1;
            else if (seen_low && mem_addr == 16'h0001 && mem_ready) found = 1'b1;
        end
        checks++;
        if (!found || instr_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sim_setup got found=%b v=%b b=%b want 1 1 1", found, instr_valid, busy);
        end
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        instr_ready = 1'b1;
        sb_q.push_back({16'h0100, word(16'h0100)});
        step();
        redirect = 1'b0;
        checks++;
        if ({instr_valid, pc, busy} !== {1'b0, 16'h0100, 1'b0}) begin
            errors++;
            $display("FAIL sim_redirect got v=%b pc=%h b=%b want 0 0100 0", instr_valid, pc, busy);
        end
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (instr_valid) found = 1'b1;
        end
        checks++;
        if (!found || {instr_pc, instr} !== sb_q[0]) begin
            errors++;
            $display("FAIL sim_first got found=%b %h want %h", found, {instr_pc, instr}, sb_q[0]);
        end
        sb_q.delete();
    endtask

    task automatic test_hold_wrap();
        bit found = 1'b0;
        bit moved = 1'b0;
        do_reset();
        instr_ready = 1'b1;
        sb_q.push_back({16'h0000, word(16'h0000)});
        sb_q.push_back({16'h0001, word(16'h0001)});
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (instr_valid) begin
                checks++;
                if (sb_q.size() == 0 || {instr_pc, instr} !== sb_q[0]) begin
                    errors++;
                    $display("FAIL hold_entry got %h", {instr_pc, instr});
                end
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end
            if (mem_addr == 16'h0001 && !mem_ready && busy) begin
                hold = 1'b1;
                found = 1'b1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (mem_addr !== 16'h0001) moved = 1'b1;
            if (instr_valid) begin
                checks++;
                if (sb_q.size() == 0 || {instr_pc, instr} !== sb_q[0]) begin
                    errors++;
                    $display("FAIL hold_entry got %h", {instr_pc, instr});
                end
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end
        end
        checks++;
        if (!found || moved || sb_q.size() != 0 || pc !== 16'h0002 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_stall got found=%b moved=%b left=%0d pc=%h b=%b want 1 0 0 0002 0",
                     found, moved, sb_q.size(), pc, busy);
        end
        hold = 1'b0;
        step();
        checks++;
        if (mem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL hold_release got a=%h want 0002", mem_addr);
        end
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        sb_q.push_back({16'hFFFF, word(16'hFFFF)});
        step();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (instr_valid) found = 1'b1;
        end
        checks++;
        if (!found || {instr_pc, instr} !== sb_q[0] || pc !== 16'h0000 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap got found=%b %h pc=%h a=%h want %h pc=0000 a=0000",
                     found, {instr_pc, instr}, pc, mem_addr, sb_q[0]);
        end
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_simultaneous();
        test_hold_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the stack processor. Drives the word address into the unified 16-bit memory, waits for that memory's `memory_ready`, and captures each fetched word with its PC into a small prefetch FIFO. The decoder drains the FIFO through a valid/ready handshake. A redirect input handles jumps and branches.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `FIFO_DEPTH`, default 2: prefetch entries; power of two, 2..8.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `hold`  in  1: blocks new fetch issues; an in-flight fetch still completes. Used while a data access owns the memory port.
- `redirect`  in  1: load `redirect_pc` as the next fetch PC; flush all prefetched state.
- `redirect_pc`  in  16: jump target.
- `mem_addr`  out  16: registered address to memory `addr`.
- `mem_data`  in  16: memory `o0`.
- `mem_ready`  in  1: memory `memory_ready`.
- `instr`  out  16: FIFO head word.
- `instr_pc`  out  16: FIFO head PC.
- `instr_valid`  out  1: FIFO non-empty.
- `instr_ready`  in  1: decoder accepts the head entry.
- `pc`  out  16: next address to fetch.
- `busy`  out  1: high when the FSM is not IDLE.

## Operation
- FSM states: IDLE, SETTLE, WAIT.
- IDLE: if `count < FIFO_DEPTH` and `!hold` and `!redirect`, then `mem_addr <= pc` and the FSM goes to SETTLE.
- SETTLE: the FSM goes to WAIT unconditionally. This gives memory one edge to sample the address, so `mem_ready` is current when WAIT samples it.
- WAIT, `mem_ready` = 0: stay in WAIT.
- WAIT, `mem_ready` = 1:
  - Push {`pc`, `mem_data`} into the FIFO.
  - `pc <= pc + 1` (mod 2^16; 16'hFFFF wraps to 16'h0000).
  - If post-push count < `FIFO_DEPTH` and `!hold`: `mem_addr <= pc + 1` and go to SETTLE.
  - Otherwise go to IDLE.
- Only one fetch is in flight at any time. Issue requires free space, so a push never meets a full FIFO.
- Pop: `instr_valid && instr_ready` advances the head. Push and pop in the same cycle leave `count` unchanged.
- `instr` and `instr_pc` come from registered FIFO storage (head read). `instr_valid = (count != 0)`.
- Redirect has priority over everything, in any state:
  - FIFO is emptied; any push or pop in that cycle is discarded.
  - In-flight fetch is abandoned; its data is never pushed.
  - `pc <= redirect_pc`, FSM goes to IDLE.
  - Issue happens on the following cycle, subject to `hold`.
- `hold` only gates issue decisions in IDLE and at WAIT completion. It never aborts SETTLE or WAIT.
- The fetch unit never drives `memory_w`. Write arbitration is outside this block.

## Timing
- Reset (asynchronous):
  - `pc` = `mem_addr` = `RESET_PC`.
  - FIFO empty: `count` = 0, `instr_valid` = 0.
  - `instr` = `instr_pc` = 0.
  - FSM = IDLE, `busy` = 0.
- Reset asserted mid-fetch: all state is lost immediately. Fetching restarts from `RESET_PC` after release.
- Let issue edge be N, i.e. `mem_addr` updates at N.
  - Address changed from memory's last address: memory drops `memory_ready` at N+1 and raises it at N+2, so the push happens at edge N+3.
  - Same address as memory's last: `mem_ready` stays high, so the push happens at N+2.
- Sequential streaming with no backpressure: one instruction per 3 cycles.
- A pushed entry is visible on `instr_valid`/`instr`/`instr_pc` after the push edge. Pop is effective at the edge where the handshake is sampled.
- First issue after reset release occurs at the first clock edge, provided `hold` = 0.

## Test plan
1. **Reset.** Assert `rst_n` = 0 mid-WAIT.
   - Immediately: `instr_valid` = 0, `mem_addr` = `pc` = 16'h0000, `busy` = 0.
2. **Sequential stream.** Memory preloaded 0x1111, 0x2222, 0x3333, 0x4444 at addresses 0..3; `instr_ready` = 1.
   - Entries arrive in order: (pc 0, 0x1111), (1, 0x2222), (2, 0x3333), (3, 0x4444).
   - Pushes 2..4 are exactly 3 cycles apart.
3. **Backpressure.** `instr_ready` = 0, `FIFO_DEPTH` = 2.
   - FIFO holds pc 0 and pc 1; `pc` = 2; `mem_addr` stays 1; FSM idles.
   - Raise `instr_ready`: pc 0 then pc 1 drain, then fetch of addr 2 issues.
4. **Redirect in WAIT.** Assert `redirect`, `redirect_pc` = 16'h0040, while addr 5 is in flight and 1 entry is queued.
   - Next cycle: `instr_valid` = 0.
   - First entry delivered afterwards has `instr_pc` = 0x0040; addr 5 data never appears.
5. **Simultaneous events.** In one cycle: `redirect`, a pop handshake, and `mem_ready` capture.
   - Redirect wins: next cycle `count` = 0 and `pc` = `redirect_pc`.
6. **Hold and wrap.** Assert `hold` during WAIT.
   - In-flight fetch completes; no new `mem_addr` change until `hold` drops.
   - Then redirect to 16'hFFFF: it fetches pc 0xFFFF, then `pc` = 0x0000.
